// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result and done pulse; optional iterative
// shift-add multiplier enabled by defining ALU_ITER_MUL_EN.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] alu_res;
   logic             slt_bit;

`ifdef ALU_ITER_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam int         CNT_W  = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_sum;

   // Only the low WIDTH bits of the product are kept, so the shifted
   // multiplicand can simply drop its overflowing bits.
   assign acc_sum = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

   assign slt_bit = ($signed(src1_i) < $signed(src2_i));

   always_comb begin
      alu_res = '0;
      case (ALUCtrl_i)
         OP_AND:  alu_res = src1_i & src2_i;
         OP_OR:   alu_res = src1_i | src2_i;
         OP_ADD:  alu_res = src1_i + src2_i;
         OP_SUB:  alu_res = src1_i - src2_i;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
`ifdef ALU_ITER_MUL_EN
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
`ifdef ALU_ITER_MUL_EN
               if (ALUCtrl_i == OP_MUL) begin
                  acc_d   = '0;
                  mcand_d = src1_i;
                  mplr_d  = src2_i;
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = S_MUL;
               end else
`endif
               begin
                  result_d = alu_res;
                  state_d  = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
`ifdef ALU_ITER_MUL_EN
         S_MUL: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d = acc_sum;
               state_d  = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

`ifdef ALU_ITER_MUL_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o = (state_q == S_MUL);
`else
   assign busy_o = 1'b0;
`endif

   assign ready_o  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign zero_o   = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         start_i;
   logic [3:0]   ALUCtrl_i;
   logic [W-1:0] src1_i, src2_i;
   logic         ready_o, busy_o, done_o, zero_o;
   logic [W-1:0] result_o;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .ALUCtrl_i(ALUCtrl_i),
      .src1_i   (src1_i),
      .src2_i   (src2_i),
      .ready_o  (ready_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
      .zero_o   (zero_o)
   );

   always #5 clk_i = ~clk_i;

`ifdef ALU_ITER_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      string        name;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the operation's meaning.
   function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint sa, sb;
      logic [2*W-1:0] prod;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return W'((longint'(a) + longint'(b)) % (64'd1 << W));
         4'd6:    return W'(a + ~b + 1);
         4'd7:    return (sa < sb) ? W'(1) : W'(0);
         4'd8:    return MUL_EN ? prod[W-1:0] : W'(0);
         default: return W'(0);
      endcase
   endfunction

   function automatic int latency(input logic [3:0] op);
      return (MUL_EN && op == 4'd8) ? W + 1 : 1;
   endfunction

   // Called at a negedge with the unit ready; returns at the negedge where done_o is seen.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string nm);
      int n;
      int busy_cnt;
      chk({nm, "_ready"}, 64'(ready_o), 64'(1));
      start_i   = 1'b1;
      ALUCtrl_i = op;
      src1_i    = a;
      src2_i    = b;
      @(negedge clk_i);
      start_i   = 1'b0;
      ALUCtrl_i = 4'($urandom);
      src1_i    = $urandom;
      src2_i    = $urandom;
      n = 1;
      busy_cnt = 0;
      while (!done_o && n < 100) begin
         if (busy_o) busy_cnt++;
         @(negedge clk_i);
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'(latency(op)));
      chk({nm, "_result"}, 64'(result_o), 64'(exp));
      chk({nm, "_zero"}, 64'(zero_o), 64'(exp == '0));
      chk({nm, "_busycycles"}, 64'(busy_cnt), 64'(latency(op) - 1));
      $display("op=%b a=%08h b=%08h -> result=%08h latency=%0d", op, a, b, result_o, n);
   endtask

   vec_t vecs[$];

   initial begin
      int n;
      bit  saw_done;
      logic [3:0] ops[6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8};

      vecs.push_back('{4'd2, 32'd5,         32'd7,         32'd12,        "add_5_7"});
      vecs.push_back('{4'd6, 32'd3,         32'd5,         32'hFFFFFFFE,  "sub_3_5"});
      vecs.push_back('{4'd7, 32'hFFFFFFFF,  32'd1,         32'd1,         "slt_neg"});
      vecs.push_back('{4'd7, 32'd1,         32'hFFFFFFFF,  32'd0,         "slt_pos"});
      vecs.push_back('{4'd7, 32'h80000000,  32'h7FFFFFFF,  32'd1,         "slt_extreme"});
      vecs.push_back('{4'd1, 32'hF0,        32'h0F,        32'hFF,        "or_f0_0f"});
      vecs.push_back('{4'd0, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  "and"});
      vecs.push_back('{4'd2, 32'hFFFFFFFF,  32'd1,         32'd0,         "add_wrap"});
      vecs.push_back('{4'd5, 32'd9,         32'd9,         32'd0,         "undef_5"});
      vecs.push_back('{4'd8, 32'd6,         32'd7,         MUL_EN ? 32'd42 : 32'd0, "mul_6_7"});
      vecs.push_back('{4'd8, 32'd123,       32'd456,       MUL_EN ? 32'd56088 : 32'd0, "mul_123_456"});
      vecs.push_back('{4'd8, 32'hFFFFFFFF,  32'hFFFFFFFF,  MUL_EN ? 32'd1 : 32'd0, "mul_ones"});

      rst_i = 1'b1; start_i = 1'b0; ALUCtrl_i = '0; src1_i = '0; src2_i = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_result", 64'(result_o), 64'(0));
      chk("rst_zero",   64'(zero_o),   64'(1));
      chk("rst_ready",  64'(ready_o),  64'(1));
      chk("rst_done",   64'(done_o),   64'(0));
      chk("rst_busy",   64'(busy_o),   64'(0));
      rst_i = 1'b0;
      @(negedge clk_i);

      // ADD then an idle cycle: done drops, result holds
      run_op(4'd2, 32'd5, 32'd7, 32'd12, "add_first");
      @(negedge clk_i);
      chk("add_done_drop", 64'(done_o), 64'(0));
      chk("add_hold",      64'(result_o), 64'(12));

      // Back-to-back single-cycle ops, one per cycle
      start_i = 1'b1; ALUCtrl_i = 4'd6; src1_i = 32'd3; src2_i = 32'd5;
      @(negedge clk_i);
      chk("b2b_sub_done", 64'(done_o), 64'(1));
      chk("b2b_sub_res",  64'(result_o), 64'hFFFFFFFE);
      ALUCtrl_i = 4'd7; src1_i = 32'hFFFFFFFF; src2_i = 32'd1;
      @(negedge clk_i);
      chk("b2b_slt_done", 64'(done_o), 64'(1));
      chk("b2b_slt_res",  64'(result_o), 64'(1));
      ALUCtrl_i = 4'd1; src1_i = 32'hF0; src2_i = 32'h0F;
      @(negedge clk_i);
      chk("b2b_or_done", 64'(done_o), 64'(1));
      chk("b2b_or_res",  64'(result_o), 64'hFF);
      start_i = 1'b0;
      @(negedge clk_i);
      chk("b2b_done_drop", 64'(done_o), 64'(0));

      foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      @(negedge clk_i);

`ifdef ALU_ITER_MUL_EN
      // A start pulse during a multiply must be ignored
      start_i = 1'b1; ALUCtrl_i = 4'd8; src1_i = 32'd123; src2_i = 32'd456;
      @(negedge clk_i);
      start_i = 1'b0;
      n = 1;
      repeat (4) begin @(negedge clk_i); n++; end
      start_i = 1'b1; ALUCtrl_i = 4'd2; src1_i = 32'd1; src2_i = 32'd1;
      chk("inmul_ready", 64'(ready_o), 64'(0));
      chk("inmul_busy",  64'(busy_o),  64'(1));
      @(negedge clk_i); n++;
      start_i = 1'b0;
      while (!done_o && n < 100) begin @(negedge clk_i); n++; end
      chk("inmul_latency", 64'(n), 64'(W + 1));
      chk("inmul_result",  64'(result_o), 64'(56088));
      @(negedge clk_i);
      chk("inmul_no_extra_done", 64'(done_o), 64'(0));
`endif

      // Reset 10 cycles into a multiply
      run_op(4'd2, 32'd1, 32'd2, 32'd3, "pre_rst_add");
      start_i = 1'b1; ALUCtrl_i = 4'd8; src1_i = 32'd123; src2_i = 32'd456;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (9) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_result", 64'(result_o), 64'(0));
      chk("arst_zero",   64'(zero_o),   64'(1));
      chk("arst_ready",  64'(ready_o),  64'(1));
      chk("arst_done",   64'(done_o),   64'(0));
      chk("arst_busy",   64'(busy_o),   64'(0));
      @(negedge clk_i);
      rst_i = 1'b0;
      saw_done = 1'b0;
      repeat (W + 8) begin
         @(negedge clk_i);
         if (done_o || busy_o) saw_done = 1'b1;
      end
      chk("arst_no_done", 64'(saw_done), 64'(0));
      run_op(4'd2, 32'd20, 32'd22, 32'd42, "post_rst_add");

      // Randomized run against the model
      for (int i = 0; i < 60; i++) begin
         logic [3:0]   op;
         logic [W-1:0] a, b;
         int sel;
         sel = $urandom_range(0, 6);
         op  = (sel < 6) ? ops[sel] : 4'($urandom);
         a   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
         b   = ($urandom_range(0, 4) == 0) ? a : W'($urandom);
         if ($urandom_range(0, 3) == 0) @(negedge clk_i);
         run_op(op, a, b, model(op, a, b), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit that consumes the 4-bit operation code produced by the ALU control decoder, together with the two register/immediate operands, and returns a registered result with a one-cycle completion pulse. Single-cycle operations (AND, OR, ADD, SUB, SLT) complete one clock after acceptance. An optional iterative shift-add multiplier takes WIDTH cycles. A valid/ready handshake lets the pipeline controller stall while a multi-cycle operation is in flight.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- clk_i  input  1  rising-edge clock
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; accepted on an edge where start_i && ready_o
- ALUCtrl_i  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 MUL
- src1_i  input  WIDTH  operand A
- src2_i  input  WIDTH  operand B
- ready_o  output  1  unit can accept a request this cycle
- busy_o  output  1  multiply in progress
- done_o  output  1  one-cycle pulse; result_o is valid from this cycle onward
- result_o  output  WIDTH  registered result, held until the next done_o
- zero_o  output  1  high when result_o == 0

## Operation
- States: IDLE, MUL, DONE.
- Reset values: state IDLE, result_o 0, zero_o 1, done_o 0, busy_o 0, ready_o 1, iteration counter 0.
- Acceptance: ALUCtrl_i, src1_i and src2_i are captured on the accepting edge. Inputs may change freely afterwards.
- Single-cycle code accepted:
  - result_o is written on the accepting edge.
  - Next state is DONE.
- Arithmetic is modulo 2^WIDTH; carries and overflow are discarded.
- SLT: result_o = {WIDTH-1 zeros, (signed A < signed B)}.
- Undefined code: result_o = 0; completes as a single-cycle op.
- MUL accepted:
  - Accumulator is cleared; multiplicand is loaded with A, multiplier with B; counter is loaded with WIDTH.
  - Next state is MUL.
- MUL state, each edge:
  - If multiplier[0], accumulator += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; counter -= 1.
  - When counter reaches 0 on that edge, result_o is loaded with the accumulator and next state is DONE.
- MUL result is the low WIDTH bits of the product, so it is identical for signed and unsigned operands. There is no early termination.
- DONE state:
  - done_o = 1.
  - If start_i is high, a new request is accepted exactly as from IDLE (back-to-back). Otherwise next state is IDLE.
- ready_o = (state == IDLE || state == DONE). busy_o = (state == MUL).
- start_i while in MUL is ignored; no request is queued.
- rst_i asserted at any time returns every register to its reset value immediately. An in-flight multiply is discarded and produces no done_o.

## Timing
- Single-cycle op accepted at edge k: done_o and result_o are valid in cycle k+1 (latency 1).
- MUL accepted at edge k: busy_o is high for cycles k+1 … k+WIDTH. done_o is high in cycle k+WIDTH+1 (latency WIDTH+1).
- Back-to-back single-cycle ops sustain one result per cycle. done_o then stays high continuously, with result_o updating every cycle.
- done_o, ready_o, busy_o and zero_o are decoded from registered state and result only; there is no combinational path from any input.

## Configuration
- ALU_ITER_MUL_EN defined:
  - MUL state, counter, accumulator and shifters are instantiated.
  - Code 1000 performs a multiply.
- ALU_ITER_MUL_EN undefined:
  - None of that logic exists; busy_o is tied to 0.
  - Code 1000 is an undefined code: result 0, latency 1.

## Test plan
- After reset: result_o=0, zero_o=1, ready_o=1, done_o=0. ADD 5+7 accepted → next cycle done_o=1, result_o=12, zero_o=0; following cycle done_o=0 and result_o holds 12.
- Back-to-back: SUB 3−5, then SLT (0xFFFFFFFF, 1), then OR (0xF0, 0x0F), one per cycle → results 0xFFFFFFFE, 1, 0xFF on three consecutive cycles, done_o high throughout.
- With the macro, WIDTH=32: MUL 123×456 → busy_o high for 32 cycles, done_o exactly 33 cycles after acceptance, result 56088. Also MUL 0xFFFFFFFF×0xFFFFFFFF → 1.
- During a MUL: pulse start_i with ADD 1+1 → request ignored, ready_o=0, and the MUL result is unchanged and on time.
- Assert rst_i 10 cycles into a MUL → all outputs at reset values immediately. No done_o follows; a new ADD is accepted normally after release.
- Without the macro: code 1000 with operands 6, 7 → done_o after 1 cycle, result_o=0, zero_o=1, busy_o never asserted.
